// File: rtl/cmd_sequencer_pkg.sv
// Shared definitions for the command sequencer: operation codes, FSM state
// encoding, command-record word/field bit positions, the decoded-field record
// and the op -> engine mapping.
package cmd_sequencer_pkg;

  // Operation codes carried in word 0 of a command record.
  localparam logic [2:0] OP_IDLE    = 3'd0;
  localparam logic [2:0] OP_CONV1   = 3'd1;
  localparam logic [2:0] OP_CONV2   = 3'd2;
  localparam logic [2:0] OP_CONV3   = 3'd3;
  localparam logic [2:0] OP_MAXPOOL = 3'd4;
  localparam logic [2:0] OP_AVEPOOL = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_ISSUE  = 3'd3,
    S_RUN    = 3'd4,
    S_FINISH = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  // Field positions inside the record words.
  localparam int W0_OP_LSB      = 0;   // [2:0]
  localparam int W0_PAD_BIT     = 4;
  localparam int W0_STRIDE_LSB  = 8;   // [11:8]
  localparam int W0_CENTER_LSB  = 16;  // [31:16]
  localparam int W2_O_CHAN_LSB  = 16;  // [31:16]
  localparam int W3_O_SIDE_LSB  = 8;   // [15:8]
  localparam int W3_KERNEL_LSB  = 16;  // [23:16]
  localparam int W4_I_SURF_LSB  = 0;   // [15:0]
  localparam int W4_O_SURF_LSB  = 16;  // [31:16]

  // Only the fields the sequencer uses or exports are kept.
  typedef struct packed {
    logic [2:0]  op;
    logic        pad;
    logic [3:0]  stride;
    logic [15:0] center;
    logic [15:0] o_chan;
    logic [7:0]  o_side;
    logic [7:0]  kernel;
    logic [15:0] i_surf;
    logic [15:0] o_surf;
    logic [31:0] weight;
    logic [31:0] data;
    logic [31:0] result;
  } cmd_fields_t;

  localparam int CMD_FIELDS_W = $bits(cmd_fields_t);

  // bit0 conv, bit1 maxpool, bit2 avepool; zero means the op is illegal.
  function automatic logic [2:0] op_to_eng(input logic [2:0] op);
    case (op)
      OP_CONV1, OP_CONV2, OP_CONV3: op_to_eng = 3'b001;
      OP_MAXPOOL:                   op_to_eng = 3'b010;
      OP_AVEPOOL:                   op_to_eng = 3'b100;
      default:                      op_to_eng = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/cmd_sequencer_unpack.sv
// cmd_unpack: pops CMD_WORDS words from the FWFT command FIFO while fetch is
// high, latching the decoded fields as their word arrives. Words 1 and 8+
// are consumed but not stored.
// Ports:
//   clk, rst        clock, async active-high reset
//   fetch           sequencer is in FETCH
//   fifo_dout/empty FIFO head word and empty flag
//   rd_en           pop strobe (combinational)
//   rec_done        last word of the record popped this cycle
//   fields          packed cmd_fields_t holding the current record
module cmd_unpack
  import cmd_sequencer_pkg::*;
#(
  parameter int CMD_WORDS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch,
  input  logic [31:0]             fifo_dout,
  input  logic                    fifo_empty,
  output logic                    rd_en,
  output logic                    rec_done,
  output logic [CMD_FIELDS_W-1:0] fields
);

  localparam int IDX_W = $clog2(CMD_WORDS);

  logic [IDX_W-1:0] idx_q, idx_d;
  cmd_fields_t      fld_q, fld_d;

  // An empty FIFO stalls the index; it never skips a word.
  assign rd_en    = fetch && !fifo_empty;
  assign rec_done = rd_en && (idx_q == IDX_W'(CMD_WORDS - 1));
  assign fields   = fld_q;

  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    idx_d = idx_q;
    fld_d = fld_q;
    if (rd_en) begin
      idx_d = rec_done ? '0 : idx_q + 1'b1;
      case (int'(idx_q))
        0: begin
          fld_d.op     = fifo_dout[W0_OP_LSB +: 3];
          fld_d.pad    = fifo_dout[W0_PAD_BIT];
          fld_d.stride = fifo_dout[W0_STRIDE_LSB +: 4];
          fld_d.center = fifo_dout[W0_CENTER_LSB +: 16];
        end
        2: fld_d.o_chan = fifo_dout[W2_O_CHAN_LSB +: 16];
        3: begin
          fld_d.o_side = fifo_dout[W3_O_SIDE_LSB +: 8];
          fld_d.kernel = fifo_dout[W3_KERNEL_LSB +: 8];
        end
        4: begin
          fld_d.i_surf = fifo_dout[W4_I_SURF_LSB +: 16];
          fld_d.o_surf = fifo_dout[W4_O_SURF_LSB +: 16];
        end
        5:       fld_d.weight = fifo_dout;
        6:       fld_d.data   = fifo_dout;
        7:       fld_d.result = fifo_dout;
        default: ;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering. The field
  // registers are plain flops (not a RAM) and are reset so outputs read 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      fld_q <= '0;
    end else begin
      idx_q <= idx_d;
      fld_q <= fld_d;
    end
  end

endmodule

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: fetches command records from the command FIFO, decodes
// them, starts one of NUM_ENG engines and counts per-pixel done pulses until
// all output channels of every surface are covered. Runs cmd_size commands,
// then raises a sticky irq; an illegal record raises irq and err instead.
// Ports:
//   clk, rst                   clock, async active-high reset
//   op_en, cmd_size            start pulse (IDLE only) and command count
//   cmd_fifo_*                 FWFT command FIFO interface
//   eng_ready / eng_valid      one-hot engine start, pixel-done pulses
//   engine_reset               high except while an op is issued/running
//   op_type .. result_start_addr  decoded fields of the current command
//   busy, irq, irq_clr, err    status and sticky interrupt/error
//   perf_cycles                RUN cycle counter
// Optional feature: define CSB_PERF_CNT_EN to build the saturating RUN-cycle
// counter; otherwise perf_cycles is tied to 0.
module cmd_sequencer
  import cmd_sequencer_pkg::*;
#(
  parameter int CMD_WORDS = 8,
  parameter int PARA      = 16,
  parameter int NUM_ENG   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_en,
  input  logic [6:0]         cmd_size,
  input  logic [31:0]        cmd_fifo_dout,
  input  logic               cmd_fifo_empty,
  output logic               cmd_fifo_rd_en,
  output logic [NUM_ENG-1:0] eng_ready,
  input  logic [NUM_ENG-1:0] eng_valid,
  output logic               engine_reset,
  output logic [2:0]         op_type,
  output logic               padding,
  output logic [3:0]         stride,
  output logic [7:0]         kernel_size,
  output logic [7:0]         o_side_size,
  output logic [15:0]        i_surf_size,
  output logic [15:0]        op_num,
  output logic [31:0]        weight_start_addr,
  output logic [31:0]        data_start_addr,
  output logic [31:0]        result_start_addr,
  output logic               busy,
  output logic               irq,
  input  logic               irq_clr,
  output logic               err,
  output logic [31:0]        perf_cycles
);

  state_e             state_q, state_d;
  logic [NUM_ENG-1:0] eng_ready_q, eng_ready_d;
  logic               engine_reset_q, engine_reset_d;
  logic               irq_q, irq_d;
  logic               err_q, err_d;
  logic [15:0]        surf_q, surf_d;
  logic [16:0]        chan_q, chan_d;
  logic [6:0]         cmds_done_q, cmds_done_d;
  logic [6:0]         cmd_size_q, cmd_size_d;

  logic [CMD_FIELDS_W-1:0] fields_flat;
  cmd_fields_t             fld;
  logic                    rec_done;
  logic                    valid_sel;
  logic                    surf_wrap;
  logic [16:0]             chan_next;
  logic                    op_done;

  cmd_unpack #(.CMD_WORDS(CMD_WORDS)) u_unpack (
    .clk        (clk),
    .rst        (rst),
    .fetch      (state_q == S_FETCH),
    .fifo_dout  (cmd_fifo_dout),
    .fifo_empty (cmd_fifo_empty),
    .rd_en      (cmd_fifo_rd_en),
    .rec_done   (rec_done),
    .fields     (fields_flat)
  );

  assign fld = cmd_fields_t'(fields_flat);

  // Pulses from engines that were not started are ignored.
  assign valid_sel = |(eng_valid & eng_ready_q);
  assign surf_wrap = (surf_q == fld.o_surf - 16'd1);
  // 17-bit so the last pass cannot wrap; o_chan need not be a PARA multiple.
  assign chan_next = chan_q + 17'(PARA);
  assign op_done   = (state_q == S_RUN) && valid_sel && surf_wrap &&
                     (chan_next >= {1'b0, fld.o_chan});

  always_comb begin
    state_d        = state_q;
    eng_ready_d    = eng_ready_q;
    engine_reset_d = engine_reset_q;
    irq_d          = irq_q;
    err_d          = err_q;
    surf_d         = surf_q;
    chan_d         = chan_q;
    cmds_done_d    = cmds_done_q;
    cmd_size_d     = cmd_size_q;
    case (state_q)
      S_IDLE: begin
        if (op_en) begin
          cmd_size_d  = cmd_size;
          cmds_done_d = '0;
          if (cmd_size == 7'd0) begin
            state_d = S_FINISH;
            irq_d   = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (rec_done) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (op_to_eng(fld.op) != 3'b000 && fld.o_surf != 16'd0 && fld.o_chan != 16'd0) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_ERR;
          err_d   = 1'b1;
          irq_d   = 1'b1;
        end
      end
      S_ISSUE: begin
        engine_reset_d = 1'b0;
        eng_ready_d    = NUM_ENG'(op_to_eng(fld.op));
        surf_d         = '0;
        chan_d         = '0;
        state_d        = S_RUN;
      end
      S_RUN: begin
        if (valid_sel) begin
          if (surf_wrap) begin
            surf_d = '0;
            chan_d = chan_next;
          end else begin
            surf_d = surf_q + 16'd1;
          end
        end
        if (op_done) begin
          eng_ready_d    = '0;
          engine_reset_d = 1'b1;
          cmds_done_d    = cmds_done_q + 7'd1;
          if (cmds_done_q + 7'd1 == cmd_size_q) begin
            state_d = S_FINISH;
            irq_d   = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FINISH, S_ERR: begin
        // Setting events only occur on entry, so a clear here never races a set.
        if (irq_clr) begin
          irq_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      eng_ready_q    <= '0;
      engine_reset_q <= 1'b1;
      irq_q          <= 1'b0;
      err_q          <= 1'b0;
      surf_q         <= '0;
      chan_q         <= '0;
      cmds_done_q    <= '0;
      cmd_size_q     <= '0;
    end else begin
      state_q        <= state_d;
      eng_ready_q    <= eng_ready_d;
      engine_reset_q <= engine_reset_d;
      irq_q          <= irq_d;
      err_q          <= err_d;
      surf_q         <= surf_d;
      chan_q         <= chan_d;
      cmds_done_q    <= cmds_done_d;
      cmd_size_q     <= cmd_size_d;
    end
  end

`ifdef CSB_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == S_IDLE && op_en) begin
      perf_d = '0;
    end else if (state_q == S_RUN && perf_q != 32'hFFFF_FFFF) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif

  assign eng_ready         = eng_ready_q;
  assign engine_reset      = engine_reset_q;
  assign irq               = irq_q;
  assign err               = err_q;
  assign busy              = (state_q != S_IDLE);
  assign op_type           = fld.op;
  assign padding           = fld.pad;
  assign stride            = fld.stride;
  assign kernel_size       = fld.kernel;
  assign o_side_size       = fld.o_side;
  assign i_surf_size       = fld.i_surf;
  assign op_num            = fld.center;
  assign weight_start_addr = fld.weight;
  assign data_start_addr   = fld.data;
  assign result_start_addr = fld.result;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Self-checking bench for cmd_sequencer. Stimulus loads command records into
// a FIFO model and pushes expected engine-start and irq events into a
// scoreboard queue; an independent monitor pops and compares each event as
// the DUT presents it. A few direct checks cover reset, stalls and latency.
module tb_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_en;
  logic [6:0]  cmd_size;
  logic [31:0] cmd_fifo_dout;
  logic        cmd_fifo_empty;
  logic        cmd_fifo_rd_en;
  logic [2:0]  eng_ready;
  logic [2:0]  eng_valid;
  logic        engine_reset;
  logic [2:0]  op_type;
  logic        padding;
  logic [3:0]  stride;
  logic [7:0]  kernel_size;
  logic [7:0]  o_side_size;
  logic [15:0] i_surf_size;
  logic [15:0] op_num;
  logic [31:0] weight_start_addr;
  logic [31:0] data_start_addr;
  logic [31:0] result_start_addr;
  logic        busy;
  logic        irq;
  logic        irq_clr;
  logic        err;
  logic [31:0] perf_cycles;

  always #5 clk = ~clk;

  cmd_sequencer dut (
    .clk               (clk),
    .rst               (rst),
    .op_en             (op_en),
    .cmd_size          (cmd_size),
    .cmd_fifo_dout     (cmd_fifo_dout),
    .cmd_fifo_empty    (cmd_fifo_empty),
    .cmd_fifo_rd_en    (cmd_fifo_rd_en),
    .eng_ready         (eng_ready),
    .eng_valid         (eng_valid),
    .engine_reset      (engine_reset),
    .op_type           (op_type),
    .padding           (padding),
    .stride            (stride),
    .kernel_size       (kernel_size),
    .o_side_size       (o_side_size),
    .i_surf_size       (i_surf_size),
    .op_num            (op_num),
    .weight_start_addr (weight_start_addr),
    .data_start_addr   (data_start_addr),
    .result_start_addr (result_start_addr),
    .busy              (busy),
    .irq               (irq),
    .irq_clr           (irq_clr),
    .err               (err),
    .perf_cycles       (perf_cycles)
  );

  // ---------------- FWFT FIFO model ----------------
  logic [31:0] fifo_mem [256];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  assign cmd_fifo_dout  = fifo_mem[rd_ptr];
  assign cmd_fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) if (cmd_fifo_rd_en) rd_ptr <= rd_ptr + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          is_irq;
    logic [2:0]  eng;
    logic [63:0] fields;
    logic [95:0] addrs;
    logic        err;
    int          valids;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] rec_w [8];
  int          valids_sent = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Builds one record into rec_w and, for a legal command, queues the
  // engine-start event with hand-supplied one-hot eng.
  task automatic add_cmd(input logic [2:0] op, input logic pad, input logic [3:0] strd,
                         input logic [15:0] center, input logic [15:0] o_ch,
                         input logic [7:0] o_side, input logic [7:0] k,
                         input logic [15:0] i_surf, input logic [15:0] o_surf,
                         input logic [31:0] w, input logic [31:0] d, input logic [31:0] r,
                         input logic [2:0] eng);
    exp_t e;
    // Junk in the unused bits of w0/w3 must not leak into any field.
    rec_w[0] = {center, 4'hF, strd, 3'b111, pad, 1'b1, op};
    rec_w[1] = 32'hDEAD_BEEF;
    rec_w[2] = {o_ch, 16'h0003};
    rec_w[3] = {8'hA5, k, o_side, 8'h1C};
    rec_w[4] = {o_surf, i_surf};
    rec_w[5] = w;
    rec_w[6] = d;
    rec_w[7] = r;
    if (eng != 3'b000) begin
      e.is_irq = 1'b0;
      e.eng    = eng;
      e.fields = {8'h00, op, pad, strd, k, o_side, i_surf, center};
      e.addrs  = {w, d, r};
      e.err    = 1'b0;
      e.valids = 0;
      sb_q.push_back(e);
    end
  endtask

  task automatic push_irq(input logic e_err, input int valids);
    exp_t e;
    e.is_irq = 1'b1;
    e.eng    = 3'b000;
    e.fields = '0;
    e.addrs  = '0;
    e.err    = e_err;
    e.valids = valids;
    sb_q.push_back(e);
  endtask

  task automatic fifo_put(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      fifo_mem[wr_ptr] = rec_w[i];
      wr_ptr++;
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [2:0] prev_ready;
    logic       prev_irq;
    exp_t       e;
    prev_ready = 3'b000;
    prev_irq   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (prev_ready == 3'b000 && eng_ready != 3'b000) begin
        check("sb_has_start", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("start_kind", e.is_irq, 0);
          check("eng_ready", eng_ready, e.eng);
          check("fields", {8'h00, op_type, padding, stride, kernel_size, o_side_size,
                           i_surf_size, op_num}, e.fields);
          check("addrs", {weight_start_addr, data_start_addr, result_start_addr}, e.addrs);
          check("engine_reset_low", engine_reset, 0);
        end
      end
      if (!prev_irq && irq) begin
        check("sb_has_irq", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("irq_kind", e.is_irq, 1);
          check("err_at_irq", err, e.err);
          check("valids_at_irq", valids_sent, e.valids);
        end
      end
      prev_ready = eng_ready;
      prev_irq   = irq;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_run(input logic [6:0] n);
    @(negedge clk);
    cmd_size    = n;
    op_en       = 1'b1;
    valids_sent = 0;
    @(negedge clk);
    op_en = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (eng_ready != 3'b000) seen = 1;
    end
    check("ready_seen", seen, 1);
  endtask

  task automatic wait_irq(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (irq) seen = 1;
    end
    check("irq_seen", seen, 1);
  endtask

  task automatic drive_valids(input int n, input logic [2:0] mask);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      eng_valid = mask;
      valids_sent++;
    end
    @(negedge clk);
    eng_valid = 3'b000;
  endtask

  task automatic clear_irq();
    @(negedge clk);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    check("busy_after_clr", busy, 0);
    check("irq_after_clr", irq, 0);
    check("err_after_clr", err, 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin : stimulus
    for (int i = 0; i < 256; i++) fifo_mem[i] = 32'h0;
    rst = 1'b1; op_en = 1'b0; cmd_size = 7'd0; eng_valid = 3'b000; irq_clr = 1'b0;
    #25;
    check("rst_eng_ready", eng_ready, 0);
    check("rst_engine_reset", engine_reset, 1);
    check("rst_busy", busy, 0);
    check("rst_irq_err", {irq, err}, 0);
    check("rst_rd_en", cmd_fifo_rd_en, 0);
    check("rst_perf", perf_cycles, 0);
    check("rst_fields", {op_type, padding, stride, kernel_size, o_side_size, i_surf_size,
                         op_num, weight_start_addr, data_start_addr, result_start_addr}, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: single conv op=2, o_surf=4, o_ch=32 -> 8 valids
    add_cmd(3'd2, 1'b1, 4'd2, 16'h1234, 16'd32, 8'd14, 8'd3, 16'd256, 16'd4,
            32'h1000_0000, 32'h2000_0040, 32'h3000_0080, 3'b001);
    fifo_put(0, 8);
    push_irq(1'b0, 8);
    start_run(7'd1);
    wait_ready(100);
    // Foreign-engine pulses, op_en while busy and irq_clr in RUN: all ignored.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      eng_valid = 3'b110; op_en = 1'b1; cmd_size = 7'd5; irq_clr = 1'b1;
    end
    @(negedge clk);
    eng_valid = 3'b000; op_en = 1'b0; cmd_size = 7'd1; irq_clr = 1'b0;
    check("t1_busy_in_run", busy, 1);
    check("t1_ready_held", eng_ready, 3'b001);
    drive_valids(8, 3'b001);
    wait_irq(20);
    check("t1_ready_dropped", {eng_ready, engine_reset}, 4'b0001);
    clear_irq();

    // 2: FIFO empty for 5+ cycles mid-record
    add_cmd(3'd1, 1'b0, 4'd1, 16'hBEEF, 16'd16, 8'h20, 8'd5, 16'h0400, 16'd1,
            32'hA000_0004, 32'hB000_0008, 32'hC000_000C, 3'b001);
    fifo_put(0, 3);
    push_irq(1'b0, 1);
    start_run(7'd1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_rd_en_stalled", cmd_fifo_rd_en, 0);
    end
    check("t2_words_popped", rd_ptr, wr_ptr);
    fifo_put(3, 8);
    wait_ready(100);
    drive_valids(1, 3'b001);
    wait_irq(20);
    clear_irq();

    // 3: maxpool then avepool, o_ch=16, o_surf=2 -> 4 valids total
    add_cmd(3'd4, 1'b0, 4'd2, 16'h0011, 16'd16, 8'd7, 8'd2, 16'd64, 16'd2,
            32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 3'b010);
    fifo_put(0, 8);
    add_cmd(3'd5, 1'b1, 4'd3, 16'h0022, 16'd16, 8'd9, 8'd4, 16'd81, 16'd2,
            32'h0000_4000, 32'h0000_5000, 32'h0000_6000, 3'b100);
    fifo_put(0, 8);
    push_irq(1'b0, 4);
    start_run(7'd2);
    wait_ready(100);
    drive_valids(2, 3'b010);
    // One cycle after op done: engine released and next record popping.
    check("t3_rd_en_latency", cmd_fifo_rd_en, 1);
    check("t3_ready_between", {eng_ready, engine_reset}, 4'b0001);
    check("t3_no_irq_between", irq, 0);
    wait_ready(100);
    drive_valids(2, 3'b100);
    wait_irq(20);
    clear_irq();

    // 4: illegal op 7 -> ERR
    add_cmd(3'd7, 1'b0, 4'd1, 16'h0007, 16'd16, 8'd4, 8'd3, 16'd16, 16'd2,
            32'h1, 32'h2, 32'h3, 3'b000);
    fifo_put(0, 8);
    push_irq(1'b1, 0);
    start_run(7'd1);
    wait_irq(100);
    check("t4_err", err, 1);
    check("t4_no_eng", eng_ready, 0);
    clear_irq();

    // 4b: legal op with o_surf=0 -> ERR
    add_cmd(3'd4, 1'b0, 4'd1, 16'h0008, 16'd16, 8'd4, 8'd3, 16'd16, 16'd0,
            32'h4, 32'h5, 32'h6, 3'b000);
    fifo_put(0, 8);
    push_irq(1'b1, 0);
    start_run(7'd1);
    wait_irq(100);
    check("t4b_err", err, 1);
    clear_irq();

    // 5: o_ch=20 (not a PARA multiple), o_surf=3 -> 6 valids
    add_cmd(3'd3, 1'b1, 4'd1, 16'h0505, 16'd20, 8'd28, 8'd1, 16'd784, 16'd3,
            32'h5555_0000, 32'h6666_0000, 32'h7777_0000, 3'b001);
    fifo_put(0, 8);
    push_irq(1'b0, 6);
    start_run(7'd1);
    wait_ready(100);
    drive_valids(6, 3'b001);
    wait_irq(20);
    clear_irq();

    // 6: async reset mid-RUN
    add_cmd(3'd2, 1'b0, 4'd1, 16'h0606, 16'd32, 8'd10, 8'd3, 16'd100, 16'd4,
            32'h0606_0001, 32'h0606_0002, 32'h0606_0003, 3'b001);
    fifo_put(0, 8);
    start_run(7'd1);
    wait_ready(100);
    drive_valids(2, 3'b001);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_ready", eng_ready, 0);
    check("t6_rst_engine_reset", engine_reset, 1);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_perf", perf_cycles, 0);
    @(negedge clk);
    rst = 1'b0;

    // 7: cmd_size=0 -> straight to FINISH without touching the FIFO
    push_irq(1'b0, 0);
    start_run(7'd0);
    wait_irq(10);
    check("t7_no_pop", rd_ptr, wr_ptr);
    clear_irq();

    repeat (5) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
